// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU result stream and a FIFO-buffered long-latency
// result stream onto the single regfile write port, and tracks pending long results.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       lng_issue,
  input  logic [4:0]                 lng_issue_rd,
  input  logic                       lng_valid,
  output logic                       lng_ready,
  input  logic [4:0]                 lng_rd,
  input  logic [XLEN-1:0]            lng_data,
  input  logic [4:0]                 chk_rs1,
  input  logic [4:0]                 chk_rs2,
  input  logic [4:0]                 chk_rd,
  output logic                       hazard,
  output logic                       wr_en,
  output logic [4:0]                 wr_rd,
  output logic [XLEN-1:0]            wr_data,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [4:0]       r_mem_rd   [DEPTH];
  logic [XLEN-1:0]  r_mem_data [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [31:0]      r_busy;
  logic             r_live;
  logic             r_wr_en;
  logic [4:0]       r_wr_rd;
  logic [XLEN-1:0]  r_wr_data;

  logic             w_alu_win;
  logic             w_pop;
  logic             w_push;
  logic [4:0]       w_head_rd;
  logic [XLEN-1:0]  w_head_data;
  logic [31:0]      w_busy_nxt;

  assign w_alu_win   = alu_valid && (alu_rd != 5'd0);
  assign w_pop       = !w_alu_win && (r_level != '0);
  assign lng_ready   = r_live && (r_level < DEPTH_L);
  assign w_push      = lng_valid && lng_ready;
  assign w_head_rd   = r_mem_rd[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  assign hazard     = r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rd];
  assign wr_en      = r_wr_en;
  assign wr_rd      = r_wr_rd;
  assign wr_data    = r_wr_data;
  assign fifo_level = r_level;

  // Set is applied after clear so a re-issue to the popped rd keeps it busy.
  always_comb begin
    // NOTE: default first so every path assigns w_busy_nxt and no latch is inferred.
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head_rd] = 1'b0;
    if (lng_issue && (lng_issue_rd != 5'd0)) w_busy_nxt[lng_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: FIFO storage has no reset; pointers and level alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= lng_rd;
      r_mem_data[r_wr_ptr] <= lng_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_busy    <= '0;
      r_live    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      r_live <= 1'b1;
      r_busy <= w_busy_nxt;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase

      // ALU has fixed priority; a long result waits in the FIFO until a free slot.
      if (w_alu_win) begin
        r_wr_en   <= 1'b1;
        r_wr_rd   <= alu_rd;
        r_wr_data <= alu_data;
      end else if (w_pop) begin
        r_wr_en   <= (w_head_rd != 5'd0);
        r_wr_rd   <= w_head_rd;
        r_wr_data <= w_head_data;
      end else begin
        r_wr_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based behavioural model of the writeback rules.
module tb_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lng_issue;
  logic [4:0]      lng_issue_rd;
  logic            lng_valid;
  logic            lng_ready;
  logic [4:0]      lng_rd;
  logic [XLEN-1:0] lng_data;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic [4:0]      chk_rd;
  logic            hazard;
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lng_issue(lng_issue), .lng_issue_rd(lng_issue_rd),
    .lng_valid(lng_valid), .lng_ready(lng_ready), .lng_rd(lng_rd), .lng_data(lng_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data), .fifo_level(fifo_level)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            m_q[$];
  logic [31:0]     m_busy;
  bit              m_live;
  logic            m_wr_en;
  logic [4:0]      m_wr_rd;
  logic [XLEN-1:0] m_wr_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hz(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy    = '0;
    m_live    = 1'b0;
    m_wr_en   = 1'b0;
    m_wr_rd   = '0;
    m_wr_data = '0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lng_issue = 0; lng_issue_rd = 0;
    lng_valid = 0; lng_rd = 0; lng_data = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    bit   exp_ready, alu_win, pop, push;
    ent_t head;
    #1;
    exp_ready = m_live && (m_q.size() < DEPTH);
    check("hazard", 64'(hazard), 64'(m_hz(chk_rs1) | m_hz(chk_rs2) | m_hz(chk_rd)));
    check("lng_ready", 64'(lng_ready), 64'(exp_ready));
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    alu_win = alu_valid && (alu_rd != 5'd0);
    pop     = !alu_win && (m_q.size() != 0);
    push    = lng_valid && exp_ready;
    if (alu_win) begin
      m_wr_en = 1'b1; m_wr_rd = alu_rd; m_wr_data = alu_data;
    end else if (pop) begin
      head      = m_q.pop_front();
      m_wr_en   = (head.rd != 5'd0);
      m_wr_rd   = head.rd;
      m_wr_data = head.data;
      m_busy[head.rd] = 1'b0;
    end else begin
      m_wr_en = 1'b0;
    end
    if (lng_issue && lng_issue_rd != 5'd0) m_busy[lng_issue_rd] = 1'b1;
    if (push) m_q.push_back('{rd: lng_rd, data: lng_data});
    m_live = 1'b1;
    @(posedge clk);
    #1;
    check("wr_en", 64'(wr_en), 64'(m_wr_en));
    check("wr_rd", 64'(wr_rd), 64'(m_wr_rd));
    check("wr_data", 64'(wr_data), 64'(m_wr_data));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle();
    model_reset();

    // Reset held for three edges
    chk_rs1 = 5; chk_rs2 = 6; chk_rd = 7;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ready", 64'(lng_ready), 64'd0);
    check("rst_hazard", 64'(hazard), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    tick();
    tick();

    // Long path alone
    lng_issue = 1; lng_issue_rd = 5; chk_rs1 = 5;
    tick();
    idle(); chk_rs1 = 5;
    lng_valid = 1; lng_rd = 5; lng_data = 32'hDEADBEEF;
    tick();
    idle(); chk_rs1 = 5;
    tick();
    check("lp_rd", 64'(wr_rd), 64'd5);
    check("lp_data", 64'(wr_data), 64'hDEADBEEF);
    tick();

    // Collision: ALU owns the port for four cycles
    idle();
    lng_issue = 1; lng_issue_rd = 7;
    tick();
    lng_issue_rd = 8;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
      lng_valid = 1;
      lng_rd    = (i == 0) ? 5'd7 : (i == 1) ? 5'd8 : 5'd10;
      lng_data  = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
      chk_rd    = 5'd7;
      tick();
    end
    idle();
    tick();
    check("col_first", 64'(wr_rd), 64'd7);
    tick();
    check("col_second", 64'(wr_rd), 64'd8);
    tick();

    // x0 handling
    lng_issue = 1; lng_issue_rd = 9;
    tick();
    idle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h22;
    lng_valid = 1; lng_rd = 9; lng_data = 32'h99;
    tick();
    idle();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h33; chk_rs1 = 9;
    tick();
    check("x0_pop_rd", 64'(wr_rd), 64'd9);
    idle();
    alu_valid = 1; alu_rd = 2; alu_data = 32'h44;
    lng_valid = 1; lng_rd = 0; lng_data = 32'h55;
    tick();
    idle();
    tick();
    check("x0_long_wr_en", 64'(wr_en), 64'd0);
    tick();

    // Simultaneous set and clear on the same rd
    lng_issue = 1; lng_issue_rd = 4;
    tick();
    idle();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h66;
    lng_valid = 1; lng_rd = 4; lng_data = 32'h44;
    tick();
    idle();
    lng_issue = 1; lng_issue_rd = 4; chk_rs2 = 4;
    tick();
    idle(); chk_rs2 = 4;
    tick();
    idle();
    tick();
    tick();

    // Async reset mid-operation
    lng_issue = 1; lng_issue_rd = 6;
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1; alu_rd = 12; alu_data = 32'h77;
      lng_valid = 1; lng_rd = (i == 0) ? 5'd6 : 5'd11; lng_data = 32'h600 + i;
      chk_rs1 = 6;
      tick();
    end
    idle(); chk_rs1 = 6;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("ar_wr_en", 64'(wr_en), 64'd0);
    check("ar_wr_rd", 64'(wr_rd), 64'd0);
    check("ar_wr_data", 64'(wr_data), 64'd0);
    check("ar_level", 64'(fifo_level), 64'd0);
    check("ar_ready", 64'(lng_ready), 64'd0);
    check("ar_hazard", 64'(hazard), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      alu_valid    = ($urandom_range(0, 99) < 45);
      alu_rd       = 5'($urandom_range(0, 7));
      alu_data     = $urandom;
      lng_issue    = ($urandom_range(0, 99) < 30);
      lng_issue_rd = 5'($urandom_range(0, 9));
      lng_valid    = ($urandom_range(0, 99) < 50);
      lng_rd       = 5'($urandom_range(0, 9));
      lng_data     = $urandom;
      chk_rs1      = 5'($urandom_range(0, 9));
      chk_rs2      = 5'($urandom_range(0, 9));
      chk_rd       = 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
